// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler
// Whack-a-mole round sequencer. Each round waits an idle gap, lights one
// pseudo-random hole, then scores a hit, a miss (wrong or multiple press) or
// a timeout before moving to the next round. A game is ROUNDS moles long.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   start      level; starts a game from IDLE or DONE
//   tick       one-cycle time-base strobe
//   btn[3:0]   synchronized button levels, bit i = hole i
//   mole[3:0]  one-hot lit hole, 0 when no mole
//   score      hits this game (saturating)
//   round_cnt  completed rounds this game
//   hit_p      one-cycle pulse per hit
//   miss_p     one-cycle pulse per miss or timeout
//   busy       high in GAP, SHOW, NEXT
//   done       high in DONE
//
// state | meaning
// IDLE  | after reset, waiting for start
// GAP   | no mole lit, counting GAP_TICKS ticks
// SHOW  | mole lit, waiting for press or SHOW_TICKS timeout
// NEXT  | one-cycle round bookkeeping
// DONE  | game over, waiting for start
module mole_round_scheduler #(
    parameter int GAP_TICKS  = 200,
    parameter int SHOW_TICKS = 500,
    parameter int ROUNDS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] btn,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [4:0] round_cnt,
    output logic       hit_p,
    output logic       miss_p,
    output logic       busy,
    output logic       done
);

    localparam int MAX_TICKS = (GAP_TICKS > SHOW_TICKS) ? GAP_TICKS : SHOW_TICKS;
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
    localparam logic [4:0]    ROUND_END = 5'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SHOW,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    lfsr, lfsr_nx;
    logic [1:0]    prev_pos, prev_pos_nx;
    logic [1:0]    pos;
    logic [3:0]    btn_q;
    logic [3:0]    rise;
    logic [3:0]    mole_nx;
    logic [7:0]    score_nx;
    logic [4:0]    round_nx;
    logic [4:0]    round_inc;
    logic          hit_nx, miss_nx;

    assign rise      = btn & ~btn_q;
    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign lfsr_nx   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // never light the same hole twice in a row
    assign pos       = (lfsr[1:0] == prev_pos) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
    assign round_inc = round_cnt + 5'd1;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        prev_pos_nx = prev_pos;
        mole_nx     = mole;
        score_nx    = score;
        round_nx    = round_cnt;
        hit_nx      = 1'b0;
        miss_nx     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_nx = 8'd0;
                    round_nx = 5'd0;
                    cnt_nx   = '0;
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (cnt == GAP_LAST) begin
                        cnt_nx      = '0;
                        state_nx    = S_SHOW;
                        mole_nx     = 4'b0001 << pos;
                        prev_pos_nx = pos;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_SHOW: begin
                // a press outranks a coincident timeout tick
                if (rise != 4'd0) begin
                    if (rise == mole) begin
                        hit_nx   = 1'b1;
                        score_nx = (score == 8'hFF) ? score : score + 8'd1;
                    end else begin
                        miss_nx = 1'b1;
                    end
                    mole_nx  = 4'd0;
                    state_nx = S_NEXT;
                end else if (tick) begin
                    if (cnt == SHOW_LAST) begin
                        miss_nx  = 1'b1;
                        mole_nx  = 4'd0;
                        state_nx = S_NEXT;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_NEXT: begin
                round_nx = round_inc;
                cnt_nx   = '0;
                state_nx = (round_inc == ROUND_END) ? S_DONE : S_GAP;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lfsr      <= 8'hA5;
            prev_pos  <= 2'd0;
            btn_q     <= 4'hF;
            mole      <= 4'd0;
            score     <= 8'd0;
            round_cnt <= 5'd0;
            hit_p     <= 1'b0;
            miss_p    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lfsr      <= lfsr_nx;
            prev_pos  <= prev_pos_nx;
            btn_q     <= btn;
            mole      <= mole_nx;
            score     <= score_nx;
            round_cnt <= round_nx;
            hit_p     <= hit_nx;
            miss_p    <= miss_nx;
            busy      <= (state_nx == S_GAP) || (state_nx == S_SHOW) || (state_nx == S_NEXT);
            done      <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_mole_round_scheduler.sv
module tb_mole_round_scheduler;

    localparam int GAP_T  = 2;
    localparam int SHOW_T = 3;
    localparam int NR     = 4;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_SHOW = 2;
    localparam int P_NEXT = 3;
    localparam int P_DONE = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       tick;
    logic [3:0] btn;
    logic [3:0] mole;
    logic [7:0] score;
    logic [4:0] round_cnt;
    logic       hit_p;
    logic       miss_p;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int tick_ph = 0;

    // reference model state
    int         m_ph;
    int         m_seen;
    int         m_score;
    int         m_round;
    int         m_prev;
    logic [7:0] m_lfsr;
    logic [3:0] m_btnq;
    logic [3:0] m_mole;
    logic       m_hit;
    logic       m_miss;

    logic [3:0] last_mole;
    int         wrong_bit;

    mole_round_scheduler #(
        .GAP_TICKS (GAP_T),
        .SHOW_TICKS(SHOW_T),
        .ROUNDS    (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tick     (tick),
        .btn      (btn),
        .mole     (mole),
        .score    (score),
        .round_cnt(round_cnt),
        .hit_p    (hit_p),
        .miss_p   (miss_p),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Game rules applied once per clock edge to the sampled inputs.
    task automatic model_edge();
        logic [3:0] rise;
        int p;
        if (rst) begin
            m_ph = P_IDLE; m_seen = 0; m_score = 0; m_round = 0; m_prev = 0;
            m_lfsr = 8'hA5; m_btnq = 4'hF; m_mole = 4'd0; m_hit = 1'b0; m_miss = 1'b0;
            return;
        end
        rise   = btn & ~m_btnq;
        m_hit  = 1'b0;
        m_miss = 1'b0;
        case (m_ph)
            P_IDLE, P_DONE: if (start) begin
                m_score = 0; m_round = 0; m_seen = 0; m_ph = P_GAP;
            end
            P_GAP: if (tick) begin
                m_seen++;
                if (m_seen == GAP_T) begin
                    m_seen = 0;
                    p = int'(m_lfsr[1:0]);
                    if (p == m_prev) p = (p + 1) % 4;
                    m_prev = p;
                    m_mole = 4'(1 << p);
                    m_ph = P_SHOW;
                end
            end
            P_SHOW: begin
                if (rise != 4'd0) begin
                    if (rise == m_mole) begin
                        m_hit = 1'b1;
                        if (m_score < 255) m_score++;
                    end else begin
                        m_miss = 1'b1;
                    end
                    m_mole = 4'd0;
                    m_ph = P_NEXT;
                end else if (tick) begin
                    m_seen++;
                    if (m_seen == SHOW_T) begin
                        m_miss = 1'b1;
                        m_mole = 4'd0;
                        m_ph = P_NEXT;
                    end
                end
            end
            P_NEXT: begin
                m_round++;
                m_seen = 0;
                m_ph = (m_round == NR) ? P_DONE : P_GAP;
            end
            default: m_ph = P_IDLE;
        endcase
        m_btnq = btn;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    task automatic compare_all();
        chk("mole", {4'd0, mole}, {4'd0, m_mole});
        chk("score", score, 8'(m_score));
        chk("round_cnt", {3'd0, round_cnt}, 8'(m_round));
        chk("hit_p", {7'd0, hit_p}, {7'd0, m_hit});
        chk("miss_p", {7'd0, miss_p}, {7'd0, m_miss});
        chk("busy", {7'd0, busy}, {7'd0, (m_ph == P_GAP || m_ph == P_SHOW || m_ph == P_NEXT)});
        chk("done", {7'd0, done}, {7'd0, (m_ph == P_DONE)});
        chk("pulse_excl", {7'd0, hit_p & miss_p}, 8'd0);
    endtask

    task automatic step();
        tick = (tick_ph == 3);
        tick_ph = (tick_ph + 1) % 4;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Steps until a mole is lit; checks it is one-hot and differs from the last one.
    task automatic wait_mole();
        for (int i = 0; i < 100 && m_mole == 4'd0; i++) step();
        chk("mole_onehot", {7'd0, $onehot(mole)}, 8'd1);
        chk("no_repeat", {7'd0, (mole != last_mole)}, 8'd1);
        last_mole = mole;
    endtask

    task automatic wait_idle_state();
        for (int i = 0; i < 100 && !(m_ph == P_GAP || m_ph == P_DONE); i++) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btn = 4'd0; tick = 1'b0;
        last_mole = 4'd0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("idle_all_zero", {busy, done, hit_p, miss_p, mole}, 8'd0);

        // game 1: hit, wrong bit, lit+other, timeout
        start = 1'b1; step(); start = 1'b0;
        chk("busy_after_start", {7'd0, busy}, 8'd1);
        wait_mole();
        btn = mole; step();
        chk("hit1_pulse", {7'd0, hit_p}, 8'd1);
        chk("hit1_score", score, 8'd1);
        chk("hit1_mole_off", {4'd0, mole}, 8'd0);
        btn = 4'd0; step();
        chk("hit1_round", {3'd0, round_cnt}, 8'd1);
        chk("hit1_pulse_len", {7'd0, hit_p}, 8'd0);

        wait_mole();
        for (int b = 0; b < 4; b++) if (mole[b]) wrong_bit = (b + 1 + int'($urandom_range(0, 2))) % 4;
        btn = 4'(1 << wrong_bit); step();
        chk("wrong_miss", {6'd0, miss_p, hit_p}, 8'd2);
        chk("wrong_score", score, 8'd1);
        btn = 4'd0; step();

        wait_mole();
        btn = mole | {mole[2:0], mole[3]}; step();
        chk("multi_miss", {6'd0, miss_p, hit_p}, 8'd2);
        chk("multi_score", score, 8'd1);
        btn = 4'd0; step();

        wait_mole();
        for (int i = 0; i < 40 && !miss_p; i++) step();
        chk("timeout_miss", {7'd0, miss_p}, 8'd1);
        step();
        chk("g1_done", {6'd0, done, busy}, 8'd2);
        chk("g1_round", {3'd0, round_cnt}, 8'd4);
        chk("g1_score", score, 8'd1);

        // game 2: all hits, first one on the timeout tick
        start = 1'b1; step(); start = 1'b0;
        chk("restart_score", score, 8'd0);
        chk("restart_done", {7'd0, done}, 8'd0);
        wait_mole();
        for (int i = 0; i < 40 && !(m_ph == P_SHOW && m_seen == SHOW_T - 1 && tick_ph == 3); i++) step();
        btn = m_mole; step();
        chk("press_on_timeout_hit", {6'd0, miss_p, hit_p}, 8'd1);
        btn = 4'd0; step();
        for (int r = 1; r < NR; r++) begin
            wait_mole();
            repeat ($urandom_range(0, 6)) step();
            btn = mole; step();
            chk("g2_hit", {7'd0, hit_p}, 8'd1);
            btn = 4'd0; step();
        end
        wait_idle_state();
        chk("g2_score", score, 8'd4);
        chk("g2_round", {3'd0, round_cnt}, 8'd4);
        chk("g2_done", {6'd0, done, busy}, 8'd2);

        // random play, start toggling freely (ignored while busy)
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 7) == 0);
            if (m_mole != 4'd0 && $urandom_range(0, 2) == 0) btn = m_mole;
            else if ($urandom_range(0, 3) == 0) btn = 4'($urandom_range(0, 15));
            step();
        end
        start = 1'b0; btn = 4'd0; step();

        // reset mid-SHOW with buttons held
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 100 && m_mole == 4'd0; i++) step();
        btn = 4'hF; rst = 1'b1; step();
        chk("rst_all_zero", {busy, done, hit_p, miss_p, mole}, 8'd0);
        chk("rst_score", score, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_hit_after_rst", {7'd0, hit_p}, 8'd0);
        end
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 60; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
